issue_stage: RTL and testbench
==============================

// Module: issue_stage
// PURPOSE
//  Decode/issue (ID) stage of the 5-stage RV32I pipeline; consumer of the hazard unit's verdicts.
//  Holds one fetched instruction, presents its rs1/rs2/rd to the hazard unit, and obeys stall_in.
//  Selects writeback data for operands when fwd*_enable_in is set, then launches a registered bundle to EX.
//  Inserts bubbles on stall/flush; drains hazard history after flush so stale forwarding cannot occur.
// PARAMETERS
//  XLEN          32  datapath/operand width
//  DRAIN_CYCLES  2   issue-blocked cycles after flush/reset (= hazard history depth)
//  CNT_W         32  perf counter width (ISSUE_PERF_CNT_EN only)
// PORTS
//  clk             in   1     Clock; single clock domain
//  reset           in   1     synchronous, active-high reset
//  fetch_valid_in  in   1     fetch offers instruction
//  fetch_instr_in  in   32    instruction word
//  fetch_pc_in     in   XLEN  its PC
//  fetch_ready_out out  1     ID accepts this cycle (transfer = valid && ready)
//  flush_in        in   1     branch redirect: kill ID and EX-bound instruction
//  rs1_out/rs2_out out  5     RegId to hazard unit and regfile read ports; 0 if unused/invalid
//  rd_out          out  5     RegId of instruction issuing; 0 if none, invalid, or flush
//  stall_in        in   1     hazard unit stall
//  fwd1_enable_in  in   1     replace op1 with wb_data_in
//  fwd2_enable_in  in   1     replace op2 with wb_data_in
//  rf_rs1_data_in  in   XLEN  regfile read data (combinational from rs1_out)
//  rf_rs2_data_in  in   XLEN  regfile read data (combinational from rs2_out)
//  wb_data_in      in   XLEN  value being written back this cycle
//  ex_valid_out    out  1     EX bundle valid (registered)
//  ex_pc_out/ex_instr_out out XLEN/32  registered
//  ex_rd_out       out  5     registered; 0 on bubble
//  ex_op1_out/ex_op2_out out XLEN  registered operands
// BEHAVIOUR
//  - Reset: id_valid=0, ex_valid_out=0, ex_rd_out=0, all ex_* data 0, state=DRAIN, drain_cnt=DRAIN_CYCLES.
//  - rs1 used by JALR,BRANCH,LOAD,STORE,OP-IMM,OP; rs2 by BRANCH,STORE,OP; rd by LUI,AUIPC,JAL,JALR,OP-IMM,OP,LOAD.
//    Unused fields present 0 (no false stall). x0 sources read 0 and are never forwarded.
//  - rs*/rd_out are 0 whenever !id_valid, state==DRAIN, or flush_in.
//  - opN = fwdN_enable_in ? wb_data_in : rf_rsN_data_in; forward beats regfile.
//  - States: RUN, DRAIN.
//  - RUN, per cycle, priority order:
//    flush_in: id_valid<=0, EX bubble, ->DRAIN, drain_cnt<=DRAIN_CYCLES-1; fetch not accepted.
//    id_valid && stall_in: ID holds; EX bubble (valid 0, rd 0); fetch_ready_out=0.
//    id_valid && !stall_in: EX <= ID + operands; ID <= fetch if transfer else id_valid<=0.
//    !id_valid: EX bubble; ID <= fetch if transfer.
//  - fetch_ready_out = (state==RUN) && !flush_in && (!id_valid || !stall_in).
//  - DRAIN: no issue, EX bubble, fetch_ready_out=0; drain_cnt decrements; drain_cnt==0 -> RUN next cycle.
//  - Latency: fetch transfer at cycle N -> earliest EX bundle at N+2; throughput 1/cycle without stalls.
//  - stall_in while !id_valid is ignored (cannot occur since rs=0).
//  - reset mid-stall/mid-drain: reset wins; restarts full drain.
// CONFIGURATION
//  ISSUE_PERF_CNT_EN defined: ports stall_cycles_out, issued_count_out [CNT_W-1:0], both reset to 0;
//   stall_cycles increments each RUN cycle with id_valid && stall_in; issued_count each valid EX launch;
//   wrap modulo 2^CNT_W. Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package: RV32I opcode constants (OPC_LUI..OPC_OP), issue state enum, EX bundle struct;
//  reuse existing Clock/RegId/Bool/RegIdReg types.
//  Sub-module rv_reg_fields: combinational instr -> {rs1,rs2,rd} with use-gating; instanced once.
// TESTING
//  1. reset then addi x1,x0,5 offered -> ready low 2 cycles, accepted cycle 3, EX valid rd=1 op1=0 next.
//  2. add x3,x1,x2 with stall_in=1 for 1 cycle -> one EX bubble, ID held, ready=0, then issues.
//  3. fwd1=1, wb_data=0xDEADBEEF, rf_rs1=0x0 -> ex_op1=0xDEADBEEF; fwd2=0 keeps rf_rs2.
//  4. sw x5,0(x6) in ID -> rd_out=0, rs2_out=5; beq -> rd_out=0; lui -> rs1/rs2_out=0.
//  5. flush_in during stall -> ID killed, EX bubble, 2 drain cycles rs/rd=0, then accept.
//  6. flush and stall_in same cycle -> flush wins; reset during DRAIN -> full drain restart.
//  7. ISSUE_PERF_CNT_EN: 3 stalls + 4 issues -> stall_cycles=3, issued_count=4.

Source files
------------

// File: rtl/issue_stage_pkg.sv
// Shared types and constants for the RV32I decode/issue stage.
package issue_stage_pkg;

    // Base-ISA major opcodes that name at least one register operand.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Architectural register index; 0 doubles as "no register".
    typedef logic [4:0] reg_id_t;

    // RUN issues normally; DRAIN blocks issue while hazard history empties.
    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } issue_state_t;

endpackage

// File: rtl/issue_stage_rv_reg_fields.sv
// rv_reg_fields: extracts rs1/rs2/rd from an RV32I instruction word, reporting 0
// for any field the opcode does not actually use so the hazard unit never stalls
// on a phantom dependency.
module rv_reg_fields
    import issue_stage_pkg::*;
(
    input  logic [31:0] instr,
    output reg_id_t     rs1,
    output reg_id_t     rs2,
    output reg_id_t     rd
);

    // funct3 and funct7/immediate bits never select a register.
    logic unused_bits;
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    // Opcode-driven use-gating of the three register fields.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        rs1 = '0;
        rs2 = '0;
        rd  = '0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rd = instr[11:7];
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                rs1 = instr[19:15];
                rd  = instr[11:7];
            end
            OPC_BRANCH, OPC_STORE: begin
                rs1 = instr[19:15];
                rs2 = instr[24:20];
            end
            OPC_OP: begin
                rs1 = instr[19:15];
                rs2 = instr[24:20];
                rd  = instr[11:7];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/issue_stage.sv
// issue_stage: ID stage of the 5-stage RV32I pipeline. Holds one fetched
// instruction, exposes its register ids to the hazard unit, applies forwarding
// and launches a registered bundle to EX. After reset or a flush, issue is
// blocked for DRAIN_CYCLES cycles so stale hazard history cannot forward.
// Optional: define ISSUE_PERF_CNT_EN to add stall/issue performance counters.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid_in,
    input  logic [31:0]     fetch_instr_in,
    input  logic [XLEN-1:0] fetch_pc_in,
    output logic            fetch_ready_out,
    input  logic            flush_in,
    output reg_id_t         rs1_out,
    output reg_id_t         rs2_out,
    output reg_id_t         rd_out,
    input  logic            stall_in,
    input  logic            fwd1_enable_in,
    input  logic            fwd2_enable_in,
    input  logic [XLEN-1:0] rf_rs1_data_in,
    input  logic [XLEN-1:0] rf_rs2_data_in,
    input  logic [XLEN-1:0] wb_data_in,
    output logic            ex_valid_out,
    output logic [XLEN-1:0] ex_pc_out,
    output logic [31:0]     ex_instr_out,
    output reg_id_t         ex_rd_out,
    output logic [XLEN-1:0] ex_op1_out,
    output logic [XLEN-1:0] ex_op2_out
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_out,
    output logic [CNT_W-1:0] issued_count_out
`endif
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    if (DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("issue_stage: DRAIN_CYCLES and CNT_W must be at least 1");
    end

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        reg_id_t         rd;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } ex_bundle_t;

    issue_state_t    state;
    logic [DW-1:0]   drain_cnt;
    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    ex_bundle_t      ex;

    reg_id_t         dec_rs1, dec_rs2, dec_rd;
    logic            id_live, issue, fetch_xfer;
    logic [XLEN-1:0] op1, op2;

    rv_reg_fields u_reg_fields (
        .instr (id_instr),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .rd    (dec_rd)
    );

    // The held instruction is visible to hazard logic only in RUN and when not being flushed.
    assign id_live         = id_valid && (state == ST_RUN) && !flush_in;
    assign issue           = id_live && !stall_in;
    assign fetch_ready_out = (state == ST_RUN) && !flush_in && (!id_valid || !stall_in);
    assign fetch_xfer      = fetch_valid_in && fetch_ready_out;

    assign rs1_out = id_live ? dec_rs1 : '0;
    assign rs2_out = id_live ? dec_rs2 : '0;
    assign rd_out  = id_live ? dec_rd  : '0;

    // x0 (or an unused source) reads as zero and is never forwarded; otherwise forward beats regfile.
    assign op1 = (rs1_out == '0) ? '0 : (fwd1_enable_in ? wb_data_in : rf_rs1_data_in);
    assign op2 = (rs2_out == '0) ? '0 : (fwd2_enable_in ? wb_data_in : rf_rs2_data_in);

    // Issue FSM, ID holding register and EX launch register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
            id_valid  <= 1'b0;
            id_instr  <= '0;
            id_pc     <= '0;
            ex        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the later
            // assignment to ex below overrides this bubble default when issuing.
            ex <= '0;
            if (issue) begin
                ex.valid <= 1'b1;
                ex.pc    <= id_pc;
                ex.instr <= id_instr;
                ex.rd    <= rd_out;
                ex.op1   <= op1;
                ex.op2   <= op2;
            end
            case (state)
                ST_RUN: begin
                    if (flush_in) begin
                        // The flush cycle itself is the first blocked cycle.
                        id_valid  <= 1'b0;
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end else if (fetch_xfer) begin
                        id_valid <= 1'b1;
                        id_instr <= fetch_instr_in;
                        id_pc    <= fetch_pc_in;
                    end else if (issue) begin
                        id_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt <= DW'(1)) begin
                        state <= ST_RUN;
                    end
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= ST_DRAIN;
            endcase
        end
    end

    assign ex_valid_out = ex.valid;
    assign ex_pc_out    = ex.pc;
    assign ex_instr_out = ex.instr;
    assign ex_rd_out    = ex.rd;
    assign ex_op1_out   = ex.op1;
    assign ex_op2_out   = ex.op2;

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, issued_count_q;

    // Count stalled RUN cycles and launched EX bundles; both wrap modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            issued_count_q <= '0;
        end else begin
            if ((state == ST_RUN) && id_valid && stall_in) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (issue) begin
                issued_count_q <= issued_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_out = stall_cycles_q;
    assign issued_count_out = issued_count_q;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Testbench for issue_stage: directed sequences followed by random traffic,
// checked against a cycle-count/queue reference model with a scoreboard.
module tb_issue_stage;

    localparam int XLEN  = 32;
    localparam int DRAIN = 2;
    localparam int CNT_W = 32;

    localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JAL = 7'h6f, O_JALR = 7'h67;
    localparam logic [6:0] O_BR = 7'h63, O_LD = 7'h03, O_ST = 7'h23, O_OPI = 7'h13, O_OP = 7'h33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic            fetch_valid_in = 1'b0;
    logic [31:0]     fetch_instr_in = '0;
    logic [XLEN-1:0] fetch_pc_in = '0;
    logic            fetch_ready_out;
    logic            flush_in = 1'b0;
    logic [4:0]      rs1_out, rs2_out, rd_out;
    logic            stall_in = 1'b0;
    logic            fwd1_enable_in = 1'b0, fwd2_enable_in = 1'b0;
    logic [XLEN-1:0] rf_rs1_data_in = '0, rf_rs2_data_in = '0, wb_data_in = '0;
    logic            ex_valid_out;
    logic [XLEN-1:0] ex_pc_out;
    logic [31:0]     ex_instr_out;
    logic [4:0]      ex_rd_out;
    logic [XLEN-1:0] ex_op1_out, ex_op2_out;
`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_out, issued_count_out;
    logic [CNT_W-1:0] exp_stalls = '0, exp_issued = '0;
`endif

    issue_stage #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid_in(fetch_valid_in), .fetch_instr_in(fetch_instr_in),
        .fetch_pc_in(fetch_pc_in), .fetch_ready_out(fetch_ready_out),
        .flush_in(flush_in), .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .stall_in(stall_in), .fwd1_enable_in(fwd1_enable_in), .fwd2_enable_in(fwd2_enable_in),
        .rf_rs1_data_in(rf_rs1_data_in), .rf_rs2_data_in(rf_rs2_data_in), .wb_data_in(wb_data_in),
        .ex_valid_out(ex_valid_out), .ex_pc_out(ex_pc_out), .ex_instr_out(ex_instr_out),
        .ex_rd_out(ex_rd_out), .ex_op1_out(ex_op1_out), .ex_op2_out(ex_op2_out)
`ifdef ISSUE_PERF_CNT_EN
        , .stall_cycles_out(stall_cycles_out), .issued_count_out(issued_count_out)
`endif
    );

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } id_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } ex_exp_t;

    id_entry_t id_q[$];      // instruction the stage should be holding (0 or 1 entries)
    ex_exp_t   sb[$];        // bundles expected on the EX port, in order
    int        cyc = 0;      // cycle index since time zero
    int        open_cyc = 0; // first cycle on which the stage may accept/issue again
    int        n_cmp = 0;
    int        n_bad = 0;
    bit        mon_en = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register usage straight from the RV32I opcode table.
    function automatic void exp_fields(input logic [31:0] ins, output logic [4:0] r1,
                                       output logic [4:0] r2, output logic [4:0] rd);
        logic [6:0] op;
        op = ins[6:0];
        r1 = (op inside {O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP}) ? ins[19:15] : 5'd0;
        r2 = (op inside {O_BR, O_ST, O_OP}) ? ins[24:20] : 5'd0;
        rd = (op inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_OPI, O_OP, O_LD}) ? ins[11:7] : 5'd0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [10];
        logic [31:0] w;
        opcs = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP, 7'h7f};
        w = $urandom;
        w[6:0]   = opcs[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // Inputs for this cycle are already driven; check combinational outputs,
    // advance the model and move on to the next negedge.
    task automatic step();
        logic       open, has, live, exp_ready;
        logic [4:0] e1, e2, ed;
        ex_exp_t    e;
        #1;
        if (reset) begin
            id_q.delete();
            open_cyc = cyc + 1 + DRAIN;
`ifdef ISSUE_PERF_CNT_EN
            exp_stalls = '0;
            exp_issued = '0;
`endif
        end else begin
            open = (cyc >= open_cyc);
            has  = (id_q.size() != 0);
            live = open && has && !flush_in;
            exp_ready = open && !flush_in && (!has || !stall_in);
            if (live) exp_fields(id_q[0].instr, e1, e2, ed);
            else begin
                e1 = '0; e2 = '0; ed = '0;
            end
            check("fetch_ready", 160'(fetch_ready_out), 160'(exp_ready));
            check("rs1_out", 160'(rs1_out), 160'(e1));
            check("rs2_out", 160'(rs2_out), 160'(e2));
            check("rd_out", 160'(rd_out), 160'(ed));
`ifdef ISSUE_PERF_CNT_EN
            if (open && has && stall_in) exp_stalls++;
`endif
            if (open && flush_in) begin
                id_q.delete();
                open_cyc = cyc + DRAIN;
            end else if (open) begin
                if (has && !stall_in) begin
                    e.pc    = id_q[0].pc;
                    e.instr = id_q[0].instr;
                    e.rd    = ed;
                    e.op1   = (e1 == 0) ? '0 : (fwd1_enable_in ? wb_data_in : rf_rs1_data_in);
                    e.op2   = (e2 == 0) ? '0 : (fwd2_enable_in ? wb_data_in : rf_rs2_data_in);
                    sb.push_back(e);
                    void'(id_q.pop_front());
`ifdef ISSUE_PERF_CNT_EN
                    exp_issued++;
`endif
                end
                if (fetch_valid_in && exp_ready) id_q.push_back('{fetch_instr_in, fetch_pc_in});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0; fetch_valid_in = 1'b0; flush_in = 1'b0; stall_in = 1'b0;
        fwd1_enable_in = 1'b0; fwd2_enable_in = 1'b0;
        rf_rs1_data_in = $urandom; rf_rs2_data_in = $urandom; wb_data_in = $urandom;
    endtask

    task automatic offer(input logic [31:0] ins);
        fetch_valid_in = 1'b1;
        fetch_instr_in = ins;
        fetch_pc_in    = 32'h1000 + 32'(cyc * 4);
    endtask

    // Monitor: every EX launch must match the oldest expected bundle; bubbles carry rd 0.
    initial begin
        ex_exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ex_valid_out) begin
                    if (sb.size() == 0) begin
                        check("ex_unexpected_issue", 160'(1), 160'(0));
                    end else begin
                        e = sb.pop_front();
                        check("ex_bundle",
                              160'({ex_pc_out, ex_instr_out, ex_rd_out, ex_op1_out, ex_op2_out}),
                              160'(e));
                    end
                end else begin
                    check("ex_bubble_rd", 160'(ex_rd_out), 160'(0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        step();                                   // cycle 0: reset sampled
        idle();
        check("reset_ex_valid", 160'(ex_valid_out), 160'(0));
        check("reset_ex_data", 160'({ex_pc_out, ex_instr_out, ex_rd_out, ex_op1_out, ex_op2_out}), 160'(0));
        mon_en = 1'b1;

        // addi x1,x0,5 offered from the first post-reset cycle: accepted on the third
        offer(32'h00500093); step(); step(); step();
        // add x3,x1,x2 accepted while addi issues
        offer(32'h002081B3); step();
        // sw x5,0(x6) offered while add is stalled for one cycle
        offer(32'h00532023); stall_in = 1'b1; step();
        // add issues with rs1 forwarded from writeback, rs2 from the regfile
        stall_in = 1'b0; fwd1_enable_in = 1'b1; wb_data_in = 32'hDEADBEEF;
        rf_rs1_data_in = 32'h0; rf_rs2_data_in = 32'h00001234;
        step();
        idle();
        offer(32'h00208063); step();              // beq x1,x2 accepted, sw issues
        offer(32'h123453B7); step();              // lui x7 accepted, beq issues
        offer(32'h002081B3); stall_in = 1'b1; step();   // lui stalled
        flush_in = 1'b1; step();                  // flush during stall wins
        idle(); offer(32'h002081B3); step();      // drain cycle
        step();                                   // accepted again
        flush_in = 1'b1; step();                  // kill it
        flush_in = 1'b0; reset = 1'b1; step();    // reset during drain
        reset = 1'b0; step(); step(); step();     // full drain, then accept

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 499) == 0);
            fetch_valid_in = ($urandom_range(0, 3) != 0);
            fetch_instr_in = rand_instr();
            fetch_pc_in    = $urandom & 32'hFFFF_FFFC;
            stall_in       = ($urandom_range(0, 3) == 0);
            flush_in       = ($urandom_range(0, 19) == 0);
            fwd1_enable_in = 1'($urandom_range(0, 1));
            fwd2_enable_in = 1'($urandom_range(0, 1));
            rf_rs1_data_in = $urandom;
            rf_rs2_data_in = $urandom;
            wb_data_in     = $urandom;
            step();
        end

        idle();
        for (int i = 0; i < 6; i++) step();
        check("scoreboard_drained", 160'(sb.size()), 160'(0));
`ifdef ISSUE_PERF_CNT_EN
        check("stall_cycles", 160'(stall_cycles_out), 160'(exp_stalls));
        check("issued_count", 160'(issued_count_out), 160'(exp_issued));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
